// File: rtl/ad_ip_jesd204_tpl_dac_chan_src.sv
// Per-channel DAC sample source: DDS, DMA, pattern, zero, PN7, PN15 or ramp, registered toward the framer.
// Define DAC_TPL_PN_INVERT_EN to add codes 4/5 (bitwise-inverted PN7/PN15).
module ad_ip_jesd204_tpl_dac_chan_src #(
    parameter int DATA_PATH_WIDTH      = 4,
    parameter int CONVERTER_RESOLUTION = 16
) (
    input  logic                            link_clk,
    input  logic                            dac_rst,
    input  logic                            dac_sync,
    input  logic [3:0]                      dac_data_sel,
    input  logic                            dac_mask_enable,
    input  logic [15:0]                     dac_pat_data_0,
    input  logic [15:0]                     dac_pat_data_1,
    input  logic [DATA_PATH_WIDTH*16-1:0]   dds_data,
    input  logic [DATA_PATH_WIDTH*16-1:0]   dma_data,
    output logic [DATA_PATH_WIDTH*16-1:0]   dac_data
);

    localparam int DW    = DATA_PATH_WIDTH * CONVERTER_RESOLUTION;
    localparam int BIT_W = $clog2(DW);

    logic [3:0]    sel_prev;
    logic          restart;
    logic          pn7_run;
    logic          pn15_run;
    logic          ramp_run;

    logic [6:0]    pn7_state;
    logic [6:0]    pn7_cur;
    logic [6:0]    pn7_adv;
    logic [DW-1:0] pn7_word;
    logic [14:0]   pn15_state;
    logic [14:0]   pn15_cur;
    logic [14:0]   pn15_adv;
    logic [DW-1:0] pn15_word;
    logic [15:0]   ramp_base;
    logic [15:0]   ramp_cur;
    logic [DW-1:0] ramp_word;
    logic [DW-1:0] pat_word;
    logic [DW-1:0] data_mux;

    // A sync pulse and a select change in the same cycle collapse into one restart.
    assign restart  = dac_sync | (dac_data_sel != sel_prev);

    // Restart reloads the seed in the same cycle, so the next beat is the sequence start.
    assign pn7_cur  = restart ? 7'h7F    : pn7_state;
    assign pn15_cur = restart ? 15'h7FFF : pn15_state;
    assign ramp_cur = restart ? 16'h0000 : ramp_base;

    always_comb begin
        pn7_run  = (dac_data_sel == 4'd6);
        pn15_run = (dac_data_sel == 4'd7);
        ramp_run = (dac_data_sel == 4'd11);
`ifdef DAC_TPL_PN_INVERT_EN
        pn7_run  = pn7_run  | (dac_data_sel == 4'd4);
        pn15_run = pn15_run | (dac_data_sel == 4'd5);
`endif
    end

    // Unrolled LFSR: first generated bit of each 16-bit slot lands in the sample MSB.
    always_comb begin
        pn7_adv  = pn7_cur;
        pn7_word = '0;
        for (int k = 0; k < DATA_PATH_WIDTH; k++) begin
            for (int j = 0; j < 16; j++) begin
                pn7_adv = {pn7_adv[5:0], pn7_adv[6] ^ pn7_adv[5]};
                pn7_word[BIT_W'(k * 16 + 15 - j)] = pn7_adv[0];
            end
        end
    end

    always_comb begin
        pn15_adv  = pn15_cur;
        pn15_word = '0;
        for (int k = 0; k < DATA_PATH_WIDTH; k++) begin
            for (int j = 0; j < 16; j++) begin
                pn15_adv = {pn15_adv[13:0], pn15_adv[14] ^ pn15_adv[13]};
                pn15_word[BIT_W'(k * 16 + 15 - j)] = pn15_adv[0];
            end
        end
    end

    for (genvar k = 0; k < DATA_PATH_WIDTH; k++) begin : g_sample
        assign ramp_word[k*16 +: 16] = ramp_cur + 16'(k);
        if (k % 2 == 0) begin : g_even
            assign pat_word[k*16 +: 16] = dac_pat_data_0;
        end else begin : g_odd
            assign pat_word[k*16 +: 16] = dac_pat_data_1;
        end
    end

    always_comb begin
        data_mux = '0;
        case (dac_data_sel)
            4'd0:    data_mux = dds_data;
            4'd1:    data_mux = pat_word;
            4'd2:    data_mux = dma_data;
            4'd6:    data_mux = pn7_word;
            4'd7:    data_mux = pn15_word;
            4'd11:   data_mux = ramp_word;
`ifdef DAC_TPL_PN_INVERT_EN
            4'd4:    data_mux = ~pn7_word;
            4'd5:    data_mux = ~pn15_word;
`endif
            default: data_mux = '0;
        endcase
    end

    always_ff @(posedge link_clk) begin
        if (dac_rst) begin
            dac_data   <= '0;
            sel_prev   <= 4'h3;
            pn7_state  <= 7'h7F;
            pn15_state <= 15'h7FFF;
            ramp_base  <= 16'h0000;
        end else begin
            dac_data   <= dac_mask_enable ? data_mux : '0;
            sel_prev   <= dac_data_sel;
            pn7_state  <= pn7_run  ? pn7_adv  : pn7_cur;
            pn15_state <= pn15_run ? pn15_adv : pn15_cur;
            ramp_base  <= ramp_run ? ramp_cur + 16'(DATA_PATH_WIDTH) : ramp_cur;
        end
    end

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_dac_chan_src.sv
// Scoreboard bench for ad_ip_jesd204_tpl_dac_chan_src (DATA_PATH_WIDTH = 4).
// Honours DAC_TPL_PN_INVERT_EN when expecting codes 4/5.
module tb_ad_ip_jesd204_tpl_dac_chan_src;

    localparam int DPW = 4;
    localparam int DW  = DPW * 16;
    localparam logic [DW-1:0] RAMP_START = 64'h0003_0002_0001_0000;

    logic          link_clk = 1'b0;
    logic          dac_rst;
    logic          dac_sync;
    logic [3:0]    dac_data_sel;
    logic          dac_mask_enable;
    logic [15:0]   dac_pat_data_0;
    logic [15:0]   dac_pat_data_1;
    logic [DW-1:0] dds_data;
    logic [DW-1:0] dma_data;
    logic [DW-1:0] dac_data;

    always #5 link_clk = ~link_clk;

    ad_ip_jesd204_tpl_dac_chan_src #(
        .DATA_PATH_WIDTH      (DPW),
        .CONVERTER_RESOLUTION (16)
    ) dut (
        .link_clk        (link_clk),
        .dac_rst         (dac_rst),
        .dac_sync        (dac_sync),
        .dac_data_sel    (dac_data_sel),
        .dac_mask_enable (dac_mask_enable),
        .dac_pat_data_0  (dac_pat_data_0),
        .dac_pat_data_1  (dac_pat_data_1),
        .dds_data        (dds_data),
        .dma_data        (dma_data),
        .dac_data        (dac_data)
    );

    int            n_cmp = 0;
    int            n_err = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] last_out;
    string         phase;

    logic [6:0]    m_pn7;
    logic [14:0]   m_pn15;
    logic [15:0]   m_ramp;
    logic [3:0]    m_prev;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic seed();
        m_pn7  = 7'h7F;
        m_pn15 = 15'h7FFF;
        m_ramp = 16'h0000;
    endtask

    // Serial software LFSRs: one bit at a time, shifted into each sample from the MSB end.
    task automatic pn7_beat(output logic [DW-1:0] v);
        logic [15:0] w[4];
        logic        b;
        for (int k = 0; k < 4; k++) begin
            w[k] = '0;
            for (int j = 0; j < 16; j++) begin
                b     = m_pn7[6] ^ m_pn7[5];
                m_pn7 = {m_pn7[5:0], b};
                w[k]  = {w[k][14:0], b};
            end
        end
        v = {w[3], w[2], w[1], w[0]};
    endtask

    task automatic pn15_beat(output logic [DW-1:0] v);
        logic [15:0] w[4];
        logic        b;
        for (int k = 0; k < 4; k++) begin
            w[k] = '0;
            for (int j = 0; j < 16; j++) begin
                b      = m_pn15[14] ^ m_pn15[13];
                m_pn15 = {m_pn15[13:0], b};
                w[k]   = {w[k][14:0], b};
            end
        end
        v = {w[3], w[2], w[1], w[0]};
    endtask

    task automatic model(output logic [DW-1:0] e);
        logic [15:0]   w[4];
        logic [DW-1:0] v;
        e = '0;
        if (dac_rst) begin
            seed();
            m_prev = 4'h3;
            return;
        end
        if (dac_sync || dac_data_sel != m_prev) seed();
        case (dac_data_sel)
            4'd0: e = dds_data;
            4'd1: e = {dac_pat_data_1, dac_pat_data_0, dac_pat_data_1, dac_pat_data_0};
            4'd2: e = dma_data;
            4'd6: pn7_beat(e);
            4'd7: pn15_beat(e);
            4'd11: begin
                for (int k = 0; k < 4; k++) w[k] = m_ramp + 16'(k);
                e = {w[3], w[2], w[1], w[0]};
                m_ramp = m_ramp + 16'd4;
            end
`ifdef DAC_TPL_PN_INVERT_EN
            4'd4: begin pn7_beat(v);  e = ~v; end
            4'd5: begin pn15_beat(v); e = ~v; end
`endif
            default: e = '0;
        endcase
        if (!dac_mask_enable) e = '0;
        m_prev = dac_data_sel;
    endtask

    task automatic step();
        logic [DW-1:0] e;
        model(e);
        exp_q.push_back(e);
        @(posedge link_clk);
        #1;
        last_out = dac_data;
        check(phase, last_out, exp_q.pop_front());
    endtask

    logic [15:0] dma_cnt;

    initial begin
        dac_rst         = 1'b1;
        dac_sync        = 1'b0;
        dac_data_sel    = 4'd3;
        dac_mask_enable = 1'b1;
        dac_pat_data_0  = 16'h0000;
        dac_pat_data_1  = 16'h0000;
        dds_data        = '0;
        dma_data        = '0;
        dma_cnt         = 16'h0000;
        m_prev          = 4'h3;
        seed();

        phase = "reset";
        step();
        step();
        check("reset_zero", last_out, '0);
        dac_rst = 1'b0;

        phase = "ramp";
        dac_data_sel = 4'd11;
        step();
        check("ramp_beat1", last_out, RAMP_START);
        step();
        check("ramp_beat2", last_out, 64'h0007_0006_0005_0004);
        for (int i = 2; i < 16384; i++) step();
        step();
        check("ramp_wrap", last_out, RAMP_START);

        phase = "pattern";
        dac_data_sel   = 4'd1;
        dac_pat_data_0 = 16'hA5A5;
        dac_pat_data_1 = 16'h5A5A;
        step();
        check("pattern_first", last_out, 64'h5A5A_A5A5_5A5A_A5A5);
        for (int i = 0; i < 3; i++) step();

        phase = "dma";
        dac_data_sel = 4'd2;
        for (int i = 0; i < 12; i++) begin
            dma_data        = {dma_cnt + 16'd3, dma_cnt + 16'd2, dma_cnt + 16'd1, dma_cnt};
            dac_mask_enable = !(i == 5 || i == 6);
            step();
            if (i == 5) check("mask_zero", last_out, '0);
            dma_cnt = dma_cnt + 16'd4;
        end
        dac_mask_enable = 1'b1;

        phase = "dds";
        dac_data_sel = 4'd0;
        for (int i = 0; i < 6; i++) begin
            dds_data = {$urandom, $urandom};
            step();
        end

        phase = "pn7";
        dac_data_sel = 4'd6;
        for (int i = 0; i < 200; i++) step();

        phase = "pn15";
        dac_data_sel = 4'd7;
        for (int i = 0; i < 5000; i++) step();

        phase = "pn15_rst";
        dac_rst = 1'b1;
        step();
        check("rst_mid_pn15", last_out, '0);
        dac_rst = 1'b0;
        phase = "pn15_after_rst";
        for (int i = 0; i < 10; i++) step();

        phase = "unused_codes";
        dac_data_sel = 4'd9;
        for (int i = 0; i < 3; i++) step();
        check("sel9_zero", last_out, '0);
        phase = "code4";
        dac_data_sel = 4'd4;
        for (int i = 0; i < 4; i++) step();
        phase = "code5";
        dac_data_sel = 4'd5;
        for (int i = 0; i < 4; i++) step();
        phase = "code15";
        dac_data_sel = 4'd15;
        step();

        phase = "ramp_restart";
        dac_data_sel = 4'd11;
        for (int i = 0; i < 1165; i++) step();
        dac_sync = 1'b1;
        step();
        check("sync_restart", last_out, RAMP_START);
        dac_sync = 1'b0;
        step();
        dac_mask_enable = 1'b0;
        step();
        step();
        dac_mask_enable = 1'b1;
        step();
        dac_data_sel = 4'd0;
        step();
        dac_data_sel = 4'd11;
        step();
        check("sel_restart", last_out, RAMP_START);

        phase = "sync_and_sel";
        dac_data_sel = 4'd6;
        dac_sync     = 1'b1;
        step();
        dac_sync = 1'b0;
        for (int i = 0; i < 4; i++) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
